frog_game_fsm: RTL and testbench
================================

FROG_GAME_FSM -- requirements
Module: frog_game_fsm

Interface
REQ-001 Parameter NUM_LOGS, default 8, number of log draw-request channels (1..256).
REQ-002 Parameter NUM_CARS, default 8, number of car draw-request channels (1..256).
REQ-003 Parameter LIVES, default 3, lives at game start (1..15).
REQ-004 Parameter GOALS_TO_WIN, default 5, goals needed to win (1..15).
REQ-005 Parameter HIT_FRAMES, default 60, frames frozen after a death (1..255).
REQ-006 clk  in  1  system clock; the one clock; all state changes on rising edge.
REQ-007 resetN  in  1  reset, asynchronous, active-low.
REQ-008 startOfFrame  in  1  one-cycle pulse at frame start.
REQ-009 frog_draw_req  in  1  frog pixel active at the current pixel.
REQ-010 logs_draw_req  in  NUM_LOGS  per-log pixel active.
REQ-011 cars_draw_req  in  NUM_CARS  per-car pixel active.
REQ-012 water_draw_req  in  1  water pixel active.
REQ-013 goal_draw_req  in  1  goal-zone pixel active.
REQ-014 start_key  in  1  level input: player start request.
REQ-015 game_state  out  3  state code: IDLE=0, PLAY=1, HIT=2, RESPAWN=3, WIN=4, GAME_OVER=5.
REQ-016 lives  out  4  remaining lives.
REQ-017 score  out  4  goals reached.
REQ-018 frog_respawn  out  1  one-cycle pulse; frog returns to start position.
REQ-019 freeze  out  1  high when object motion must stop.

Function
REQ-020 Per pixel cycle, sticky frame flags SHALL be set: car_hit = frog & OR(cars); drown = frog & water & ~OR(logs); goal_hit = frog & goal.
REQ-021 Flags SHALL be evaluated and cleared on startOfFrame; evaluation uses values accumulated before that cycle; that cycle's pixel inputs are discarded.
REQ-022 IDLE: on start_key high -> RESPAWN, with lives=LIVES and score=0 loaded.
REQ-023 PLAY at startOfFrame: car_hit or drown -> HIT with lives decremented by 1; otherwise goal_hit -> score incremented by 1, then WIN if the new score == GOALS_TO_WIN, else RESPAWN; otherwise stay in PLAY.
REQ-024 Priority SHALL be death over goal when both occur in one frame.
REQ-025 HIT: frame counter loads 0 on entry and increments on each startOfFrame; after HIT_FRAMES frames -> GAME_OVER if lives==0, else RESPAWN.
REQ-026 RESPAWN SHALL last exactly one cycle, assert frog_respawn, then -> PLAY.
REQ-027 WIN and GAME_OVER: hold until start_key rises (0->1 edge, registered), then -> IDLE.
REQ-028 A start_key level held from a previous game SHALL NOT re-trigger WIN/GAME_OVER exit.
REQ-029 start_key SHALL be ignored in PLAY, HIT and RESPAWN.
REQ-030 freeze SHALL be 1 in IDLE, HIT, WIN and GAME_OVER, and 0 in PLAY and RESPAWN.
REQ-031 lives SHALL never wrap below 0; score SHALL never exceed GOALS_TO_WIN.
REQ-032 All outputs SHALL be registered; a state change is visible the cycle after the deciding edge.

Reset
REQ-033 resetN low SHALL immediately force: state IDLE, lives=0, score=0, frog_respawn=0, freeze=1, flags and counter cleared.
REQ-034 Reset asserted mid-game SHALL abandon the game; after release, play resumes only via start_key.

Configuration
REQ-035 Macro FROG_DROWN_EN: when defined, drown is a death cause as in REQ-020/023.
REQ-036 Without FROG_DROWN_EN: the drown flag is not built, water_draw_req is ignored, and only cars cause death.

Verification
REQ-037 Reset, start_key=1 -> RESPAWN one cycle, frog_respawn pulse, lives=3, score=0, state=PLAY.
REQ-038 PLAY, frog and car 2 overlap one pixel -> next startOfFrame: HIT, lives=2, freeze=1; after 60 frames: RESPAWN, then PLAY.
REQ-039 Same frame with car overlap and goal overlap -> HIT, score unchanged, lives decremented.
REQ-040 Five goal frames -> score=5, state=WIN; start_key held high -> stays WIN; release, then press -> IDLE.
REQ-041 FROG_DROWN_EN defined: frog over water, no log -> HIT; frog over water and log 0 -> stays PLAY; macro undefined: water only -> stays PLAY.
REQ-042 Third death with lives=1 -> lives=0, after HIT_FRAMES -> GAME_OVER; resetN pulse mid-HIT -> IDLE, lives=0.

Source files
------------

// File: rtl/frog_game_fsm.sv
// Frogger-style game controller: collision flags per frame, lives/score, hit freeze and respawn.
// Optional macro FROG_DROWN_EN adds drowning (frog over water without a log) as a death cause.
module frog_game_fsm #(
  parameter int NUM_LOGS     = 8,
  parameter int NUM_CARS     = 8,
  parameter int LIVES        = 3,
  parameter int GOALS_TO_WIN = 5,
  parameter int HIT_FRAMES   = 60
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                startOfFrame,
  input  logic                frog_draw_req,
  input  logic [NUM_LOGS-1:0] logs_draw_req,
  input  logic [NUM_CARS-1:0] cars_draw_req,
  input  logic                water_draw_req,
  input  logic                goal_draw_req,
  input  logic                start_key,
  output logic [2:0]          game_state,
  output logic [3:0]          lives,
  output logic [3:0]          score,
  output logic                frog_respawn,
  output logic                freeze
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLAY      = 3'd1,
    S_HIT       = 3'd2,
    S_RESPAWN   = 3'd3,
    S_WIN       = 3'd4,
    S_GAME_OVER = 3'd5
  } state_t;

  localparam logic [3:0] LIVES_INIT = 4'(LIVES);
  localparam logic [3:0] GOAL_MAX   = 4'(GOALS_TO_WIN);
  localparam logic [7:0] HIT_LAST   = 8'(HIT_FRAMES - 1);

  state_t     state, state_nx;
  logic [3:0] lives_nx, score_nx;
  logic [7:0] hit_cnt, hit_cnt_nx;
  logic       car_hit, goal_hit, start_prev, start_rise, death;

  assign game_state = state;
  assign start_rise = start_key & ~start_prev;

`ifdef FROG_DROWN_EN
  logic drown;
  assign death = car_hit | drown;
`else
  logic unused_inputs;
  assign unused_inputs = water_draw_req ^ (^logs_draw_req);
  assign death = car_hit;
`endif

  // Sticky per-frame collision flags; the startOfFrame cycle's pixels are dropped.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      car_hit  <= 1'b0;
      goal_hit <= 1'b0;
`ifdef FROG_DROWN_EN
      drown    <= 1'b0;
`endif
    end else if (startOfFrame) begin
      car_hit  <= 1'b0;
      goal_hit <= 1'b0;
`ifdef FROG_DROWN_EN
      drown    <= 1'b0;
`endif
    end else begin
      if (frog_draw_req && (|cars_draw_req)) car_hit <= 1'b1;
      if (frog_draw_req && goal_draw_req)    goal_hit <= 1'b1;
`ifdef FROG_DROWN_EN
      if (frog_draw_req && water_draw_req && !(|logs_draw_req)) drown <= 1'b1;
`endif
    end
  end

  always_comb begin
    state_nx   = state;
    lives_nx   = lives;
    score_nx   = score;
    hit_cnt_nx = hit_cnt;
    case (state)
      S_IDLE: begin
        if (start_key) begin
          state_nx = S_RESPAWN;
          lives_nx = LIVES_INIT;
          score_nx = 4'd0;
        end
      end
      S_PLAY: begin
        if (startOfFrame) begin
          if (death) begin
            state_nx   = S_HIT;
            hit_cnt_nx = 8'd0;
            if (lives != 4'd0) lives_nx = lives - 4'd1;
          end else if (goal_hit) begin
            if (score < GOAL_MAX) score_nx = score + 4'd1;
            state_nx = (score_nx == GOAL_MAX) ? S_WIN : S_RESPAWN;
          end
        end
      end
      S_HIT: begin
        if (startOfFrame) begin
          if (hit_cnt == HIT_LAST) state_nx = (lives == 4'd0) ? S_GAME_OVER : S_RESPAWN;
          else hit_cnt_nx = hit_cnt + 8'd1;
        end
      end
      S_RESPAWN: state_nx = S_PLAY;
      S_WIN, S_GAME_OVER: begin
        if (start_rise) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= S_IDLE;
      lives        <= 4'd0;
      score        <= 4'd0;
      hit_cnt      <= 8'd0;
      start_prev   <= 1'b0;
      frog_respawn <= 1'b0;
      freeze       <= 1'b1;
    end else begin
      state        <= state_nx;
      lives        <= lives_nx;
      score        <= score_nx;
      hit_cnt      <= hit_cnt_nx;
      start_prev   <= start_key;
      frog_respawn <= (state_nx == S_RESPAWN);
      freeze       <= (state_nx inside {S_IDLE, S_HIT, S_WIN, S_GAME_OVER});
    end
  end

endmodule

// File: tb/tb_frog_game_fsm.sv
// Bench for frog_game_fsm: random pixel traffic against a frame-level game model,
// expected outputs queued per cycle and compared by a separate monitor.
module tb_frog_game_fsm;
  localparam int NL = 8, NC = 8, LV = 3, GW = 5, HF = 60, FRAME_LEN = 8;
`ifdef FROG_DROWN_EN
  localparam bit DROWN_ON = 1'b1;
`else
  localparam bit DROWN_ON = 1'b0;
`endif

  logic          clk, resetN, startOfFrame, frog_draw_req, water_draw_req, goal_draw_req, start_key;
  logic [NL-1:0] logs_draw_req;
  logic [NC-1:0] cars_draw_req;
  logic [2:0]    game_state;
  logic [3:0]    lives, score;
  logic          frog_respawn, freeze;

  frog_game_fsm #(.NUM_LOGS(NL), .NUM_CARS(NC), .LIVES(LV), .GOALS_TO_WIN(GW), .HIT_FRAMES(HF)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .frog_draw_req(frog_draw_req),
    .logs_draw_req(logs_draw_req), .cars_draw_req(cars_draw_req), .water_draw_req(water_draw_req),
    .goal_draw_req(goal_draw_req), .start_key(start_key), .game_state(game_state), .lives(lives),
    .score(score), .frog_respawn(frog_respawn), .freeze(freeze)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // game model: mode codes are the published state codes
  int m_mode, m_lives, m_score, m_frames_in_hit;
  bit m_car, m_drown, m_goal, m_key_prev;
  logic [12:0] exp_q[$];
  int n_cmp = 0, n_err = 0;

  function automatic logic [12:0] expect_out();
    logic resp, frz;
    resp = (m_mode == 3);
    frz  = (m_mode == 0) || (m_mode == 2) || (m_mode == 4) || (m_mode == 5);
    return {3'(m_mode), 4'(m_lives), 4'(m_score), resp, frz};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_lives = 0; m_score = 0; m_frames_in_hit = 0;
    m_car = 0; m_drown = 0; m_goal = 0; m_key_prev = 0;
  endtask

  task automatic model_step(input bit sof, input bit frog, input logic [NL-1:0] lg,
                            input logic [NC-1:0] cr, input bit wat, input bit gl, input bit key);
    bit dead, reached;
    dead    = m_car || (DROWN_ON && m_drown);
    reached = m_goal;
    if (sof) begin
      m_car = 0; m_drown = 0; m_goal = 0;
    end else begin
      if (frog && cr != 0)            m_car = 1;
      if (frog && wat && lg == 0)     m_drown = 1;
      if (frog && gl)                 m_goal = 1;
    end
    case (m_mode)
      0: if (key) begin m_mode = 3; m_lives = LV; m_score = 0; end
      1: if (sof) begin
           if (dead) begin
             m_mode = 2; m_frames_in_hit = 0;
             if (m_lives > 0) m_lives--;
           end else if (reached) begin
             m_score++;
             m_mode = (m_score == GW) ? 4 : 3;
           end
         end
      2: if (sof) begin
           m_frames_in_hit++;
           if (m_frames_in_hit == HF) m_mode = (m_lives == 0) ? 5 : 3;
         end
      3: m_mode = 1;
      default: if (key && !m_key_prev) m_mode = 0;
    endcase
    m_key_prev = key;
  endtask

  // driver tasks
  task automatic cycle(input bit sof, input bit frog, input logic [NL-1:0] lg,
                       input logic [NC-1:0] cr, input bit wat, input bit gl, input bit key);
    @(negedge clk);
    resetN = 1'b1;
    startOfFrame = sof; frog_draw_req = frog; logs_draw_req = lg; cars_draw_req = cr;
    water_draw_req = wat; goal_draw_req = gl; start_key = key;
    model_step(sof, frog, lg, cr, wat, gl, key);
    exp_q.push_back(expect_out());
  endtask

  // kind: 0 quiet, 1 car 2 hit, 2 goal, 3 car+goal, 4 water no log, 5 water on log 0, 6 random
  task automatic frame(input int kind, input int key_mode);
    bit frog, wat, gl, key;
    logic [NL-1:0] lg;
    logic [NC-1:0] cr;
    for (int i = 0; i < FRAME_LEN; i++) begin
      lg = NL'($urandom()); cr = NC'($urandom());
      wat = 1'($urandom()); gl = 1'($urandom()); frog = 1'b0;
      key = (key_mode == 2) ? 1'($urandom()) : key_mode[0];
      if (i == 0) frog = 1'($urandom());
      else if (kind == 6) begin
        frog = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 5) != 0) cr = '0;
        gl = ($urandom_range(0, 3) == 0);
      end else if (i == 3 && kind != 0) begin
        frog = 1'b1; cr = '0; wat = 1'b0; gl = 1'b0;
        case (kind)
          1: cr = NC'(4);
          2: gl = 1'b1;
          3: begin cr = NC'(4); gl = 1'b1; end
          4: begin wat = 1'b1; lg = '0; end
          5: begin wat = 1'b1; lg = NL'(1); end
          default: ;
        endcase
      end
      cycle(i == 0, frog, lg, cr, wat, gl, key);
    end
  endtask

  task automatic quiet_frames(input int n, input int key_mode);
    for (int k = 0; k < n; k++) frame(0, key_mode);
  endtask

  task automatic do_reset();
    logic [12:0] e;
    @(negedge clk);
    resetN = 1'b0;
    startOfFrame = 0; frog_draw_req = 0; logs_draw_req = '0; cars_draw_req = '0;
    water_draw_req = 0; goal_draw_req = 0; start_key = 0;
    model_reset();
    e = expect_out();
    exp_q.push_back(e);
    #1;
    n_cmp++;
    if ({game_state, lives, score, frog_respawn, freeze} !== e) begin
      n_err++;
      $display("FAIL async_reset: got st=%0d lives=%0d score=%0d resp=%0b frz=%0b, expected st=%0d lives=%0d score=%0d resp=%0b frz=%0b",
               game_state, lives, score, frog_respawn, freeze, e[12:10], e[9:6], e[5:2], e[1], e[0]);
    end
  endtask

  // scoreboard monitor
  initial begin
    logic [12:0] e, g;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {game_state, lives, score, frog_respawn, freeze};
        n_cmp++;
        if (g !== e) begin
          n_err++;
          $display("FAIL cycle @%0t: got st=%0d lives=%0d score=%0d resp=%0b frz=%0b, expected st=%0d lives=%0d score=%0d resp=%0b frz=%0b",
                   $time, g[12:10], g[9:6], g[5:2], g[1], g[0], e[12:10], e[9:6], e[5:2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    resetN = 1'b0; startOfFrame = 0; frog_draw_req = 0; logs_draw_req = '0; cars_draw_req = '0;
    water_draw_req = 0; goal_draw_req = 0; start_key = 0;
    model_reset();
    do_reset();
    quiet_frames(2, 0);
    frame(0, 1);
    frame(0, 2);
    frame(1, 2);
    quiet_frames(62, 2);
    frame(3, 0);
    quiet_frames(62, 0);
    frame(4, 0);
    frame(5, 0);
    quiet_frames(62, 0);
    repeat (4) frame(2, 0);
    frame(2, 1);
    quiet_frames(3, 1);
    quiet_frames(1, 0);
    frame(0, 1);
    quiet_frames(1, 0);
    repeat (3) begin
      frame(1, 0);
      quiet_frames(62, 0);
    end
    quiet_frames(1, 0);
    frame(0, 1);
    frame(1, 0);
    quiet_frames(10, 0);
    do_reset();
    quiet_frames(2, 0);
    frame(0, 1);
    repeat (150) frame(6, 2);
    @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
